pipe_reg_chain: RTL and testbench
=================================

// Module: pipe_reg_chain
// PURPOSE
//   Parametrised elastic pipeline register: a chain of DEPTH flopr-style stages with
//   per-stage valid bits, valid/ready handshake, stall hold, synchronous flush and an
//   occupancy count. Next-generation replacement for bare flopr between datapath stages.
//   It decouples producer and consumer timing in the pipelined datapath.
// PARAMETERS
//   WIDTH  64  data bits per stage
//   DEPTH  3   number of register stages (>=1; DEPTH=0 is illegal, elaboration $error)
// PORTS
//   clk        in   1                   clock, all state updates on posedge
//   reset      in   1                   async reset, active-low (0 = reset)
//   flush      in   1                   sync flush: discard all stage contents
//   in_valid   in   1                   producer has data on in_data
//   in_ready   out  1                   chain accepts in_data this cycle
//   in_data    in   WIDTH               input word
//   out_valid  out  1                   valid[DEPTH-1]
//   out_ready  in   1                   consumer accepts out_data this cycle
//   out_data   out  WIDTH               data[DEPTH-1]
//   occupancy  out  $clog2(DEPTH+1)     number of stages with valid=1
// BEHAVIOUR
//   - Reset (reset==0, async): all valid<=0, all data<=0, occupancy=0, out_valid=0,
//     out_data=0. Outputs stay so until first posedge after reset returns to 1.
//   - Stage i holds valid[i], data[i]. rdy[DEPTH]=out_ready; rdy[i]=!valid[i]|rdy[i+1]
//     (combinational, bubble-collapsing). in_ready = rdy[0] & !flush.
//   - On posedge, for each stage with rdy[i]=1: valid[i]<=prev valid, data[i]<=prev data
//     (prev of stage 0 = in_valid/in_data). Stages with rdy[i]=0 hold both.
//   - data[i] loads only when valid source present (prev valid=1); else data holds,
//     valid<=0. Data of an invalid stage is don't-care but must not be X after reset.
//   - Transfer in: in_valid&in_ready. Transfer out: out_valid&out_ready.
//   - Latency DEPTH cycles in->out with out_ready=1; throughput 1 word/cycle.
//   - Full: all valid=1 and out_ready=0 -> in_ready=0, chain frozen, nothing lost.
//   - Simultaneous in and out transfer when full: accepted (rdy ripples), occupancy same.
//   - flush=1: next posedge all valid<=0, occupancy<=0; flush beats load/hold; input on
//     that cycle is not accepted (in_ready=0). out_valid still reflects pre-flush state
//     in the flush cycle; an out transfer in that cycle counts as delivered.
//   - occupancy = popcount(valid), registered alongside valid; range 0..DEPTH.
//   - Reset asserted mid-stream: immediate clear, no partial words emitted afterward.
// CONFIGURATION
//   PIPE_STALL_CNT_EN defined: adds port stall_cnt out 32 bits; increments each posedge
//     with out_valid=1 & out_ready=0; saturates at 32'hFFFF_FFFF; cleared only by reset
//     (not by flush); reset value 0.
//   Not defined: port and counter absent; all other behaviour identical.
// TESTING  (WIDTH=64, DEPTH=3)
//   1 reset=0 for 100ns with in_valid=1 -> out_valid=0, out_data=0, occupancy=0.
//   2 out_ready=1, stream 64'h1,64'h6523,64'habcde on 3 cycles -> out_data 64'h1 valid
//     exactly 3 cycles after first accept, then 6523, abcde back-to-back.
//   3 out_ready=0, push 64'h5555,8956,fabd,bbdd -> first three accepted, in_ready=0 on
//     4th, occupancy=3; release out_ready -> 5555,8956,fabd,bbdd in order, none lost.
//   4 chain full, flush=1 one cycle with in_valid=1 data 64'h8888 -> occupancy=0,
//     out_valid=0 next cycle, 8888 never emitted.
//   5 bubble: push 64'h223432, gap 2 cycles, push 64'h1 with out_ready=0 -> both collapse
//     into stages 2,1; occupancy=2.
//   6 PIPE_STALL_CNT_EN: hold out_valid=1,out_ready=0 for 10 cycles -> stall_cnt=10; flush
//     -> still 10; reset=0 -> 0.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: elastic chain of DEPTH valid/ready register stages with
// bubble collapsing, stall hold, synchronous flush and a registered occupancy.
// Ports: clk, reset (async, active-low), flush, in_valid/in_ready/in_data,
//   out_valid/out_ready/out_data, occupancy (popcount of stage valids).
// Option: define PIPE_STALL_CNT_EN to add stall_cnt (saturating count of
//   cycles with out_valid=1 and out_ready=0; cleared only by reset).
module pipe_reg_chain #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 3,
    localparam int OW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OW-1:0]    occupancy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("pipe_reg_chain: DEPTH must be >= 1");
    end

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] load;
    logic [OW-1:0]    occ_q;
    logic             all_v;

    function automatic logic [OW-1:0] popcnt(input logic [DEPTH-1:0] v);
        logic [OW-1:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + OW'(v[i]);
        end
        return n;
    endfunction

    // A stage can advance when it or any stage downstream holds a bubble,
    // or the consumer takes the last word. Flattened form of the ready
    // ripple rdy[i] = !valid[i] | rdy[i+1], rdy[DEPTH] = out_ready.
    always_comb begin
        rdy   = '0;
        all_v = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            all_v  = all_v & valid_q[i];
            rdy[i] = out_ready | ~all_v;
        end
    end

    always_comb begin
        valid_d = valid_q;
        load    = '0;
        if (flush) begin
            valid_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    valid_d[i] = (i == 0) ? in_valid : valid_q[i-1];
                    load[i]    = valid_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= popcnt(valid_d);
            // Data only moves with a valid source; bubbles leave it as is.
            for (int i = 0; i < DEPTH; i++) begin
                if (load[i]) begin
                    data_q[i] <= (i == 0) ? in_data : data_q[i-1];
                end
            end
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign occupancy = occ_q;

`ifdef PIPE_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: scoreboard bench for pipe_reg_chain (WIDTH=64, DEPTH=3).
// Accepted words are queued on input and checked in order on output.
module tb_pipe_reg_chain;

    localparam int W = 64;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0]  stall_cnt;
`endif

    pipe_reg_chain #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           c;
    } ent_t;

    ent_t q[$];
    ent_t e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;
    bit   chk_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: sampled on the falling edge, half a cycle from any update.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_unexpected: got %h, required no output", out_data);
                end else begin
                    e = q.pop_front();
                    if (out_data !== e.d) begin
                        n_bad++;
                        $display("FAIL sb_data: got %h, required %h", out_data, e.d);
                    end
                    if (chk_lat) begin
                        n_cmp++;
                        if (cyc - e.c != D) begin
                            n_bad++;
                            $display("FAIL latency: got %0d, required %0d", cyc - e.c, D);
                        end
                    end
                end
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back('{in_data, cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_data = 64'hdead_beef;
        #100;
        n_cmp += 3;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_valid: got %b, required 0", out_valid);
        end
        if (out_data !== '0) begin
            n_bad++; $display("FAIL rst_data: got %h, required 0", out_data);
        end
        if (occupancy !== 2'd0) begin
            n_bad++; $display("FAIL rst_occ: got %0d, required 0", occupancy);
        end
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        logic [W-1:0] w [3] = '{64'h1, 64'h6523, 64'habcde};
        int base = n_out;
        chk_lat   = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = w[k];
            tick();
        end
        drain();
        chk_lat = 1'b0;
        n_cmp++;
        if (n_out - base != 3 || q.size() != 0) begin
            n_bad++;
            $display("FAIL stream_cnt: got %0d, required 3", n_out - base);
        end
    endtask

    task automatic test_full();
        logic [W-1:0] w [4] = '{64'h5555, 64'h8956, 64'hfabd, 64'hbbdd};
        int base = n_out;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = w[k];
            @(negedge clk);
            n_cmp++;
            if (in_ready !== (k < 3)) begin
                n_bad++;
                $display("FAIL full_rdy%0d: got %b, required %b", k, in_ready, k < 3);
            end
            tick();
        end
        tick();
        @(negedge clk);
        n_cmp += 3;
        if (occupancy !== 2'd3) begin
            n_bad++; $display("FAIL full_occ: got %0d, required 3", occupancy);
        end
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL full_hold_rdy: got %b, required 0", in_ready);
        end
        if (out_data !== 64'h5555 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL full_frozen: got %h, required 5555", out_data);
        end
        tick();
        out_ready = 1'b1;
        tick();
        drain();
        n_cmp++;
        if (n_out - base != 4 || q.size() != 0) begin
            n_bad++;
            $display("FAIL full_cnt: got %0d, required 4", n_out - base);
        end
    endtask

    task automatic test_flush();
        int base = n_out;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 64'h7000 + W'(k);
            tick();
        end
        in_data = 64'h8888;
        flush   = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL flush_rdy: got %b, required 0", in_ready);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp += 2;
        if (occupancy !== 2'd0) begin
            n_bad++; $display("FAIL flush_occ: got %0d, required 0", occupancy);
        end
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL flush_valid: got %b, required 0", out_valid);
        end
        drain();
        n_cmp++;
        if (n_out - base != 0) begin
            n_bad++;
            $display("FAIL flush_emit: got %0d, required 0", n_out - base);
        end
    endtask

    task automatic test_bubble();
        int base = n_out;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h223432;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1;
        in_data  = 64'h1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_cmp += 3;
        if (occupancy !== 2'd2) begin
            n_bad++; $display("FAIL bub_occ: got %0d, required 2", occupancy);
        end
        if (out_valid !== 1'b1 || out_data !== 64'h223432) begin
            n_bad++; $display("FAIL bub_head: got %h, required 223432", out_data);
        end
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL bub_rdy: got %b, required 1", in_ready);
        end
        tick();
        drain();
        n_cmp++;
        if (n_out - base != 2 || q.size() != 0) begin
            n_bad++;
            $display("FAIL bub_cnt: got %0d, required 2", n_out - base);
        end
    endtask

    task automatic test_back_to_back();
        int base = n_out;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 64'h9000 + W'(k);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data = {$urandom(), $urandom()};
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b1 || occupancy !== 2'd3) begin
                n_bad++;
                $display("FAIL b2b_%0d: got rdy=%b occ=%0d, required rdy=1 occ=3",
                         k, in_ready, occupancy);
            end
            tick();
        end
        drain();
        n_cmp++;
        if (n_out - base != 9 || q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_cnt: got %0d, required 9", n_out - base);
        end
    endtask

    task automatic test_midreset();
        int base = n_out;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'haaaa;
        tick();
        in_data = 64'hbbbb;
        tick();
        in_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp += 2;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mrst_clr: got occ=%0d v=%b, required 0 0", occupancy, out_valid);
        end
        if (out_data !== '0) begin
            n_bad++; $display("FAIL mrst_data: got %h, required 0", out_data);
        end
        tick();
        reset = 1'b1;
        drain();
        n_cmp++;
        if (n_out - base != 0) begin
            n_bad++;
            $display("FAIL mrst_emit: got %0d, required 0", n_out - base);
        end
    endtask

`ifdef PIPE_STALL_CNT_EN
    task automatic test_stall_cnt();
        n_cmp++;
        if (stall_cnt !== 32'd0) begin
            n_bad++; $display("FAIL stall_init: got %0d, required 0", stall_cnt);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h5a5a;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && out_valid !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (stall_cnt !== 32'd10) begin
            n_bad++; $display("FAIL stall_10: got %0d, required 10", stall_cnt);
        end
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        n_cmp++;
        if (stall_cnt !== 32'd10) begin
            n_bad++; $display("FAIL stall_flush: got %0d, required 10", stall_cnt);
        end
        reset = 1'b0;
        #3;
        n_cmp++;
        if (stall_cnt !== 32'd0) begin
            n_bad++; $display("FAIL stall_rst: got %0d, required 0", stall_cnt);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask
`endif

    initial begin
        #200us;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_flush();
        test_bubble();
        test_back_to_back();
        test_midreset();
`ifdef PIPE_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
